// File: rtl/sum_display.sv
// sum_display: accepts a 5-bit adder sum over a valid/ready handshake,
// converts it to two BCD digits with a sequential shift-add-3 engine and
// drives a time-multiplexed two-digit seven-segment display.
module sum_display #(
    parameter int SCAN_DIV      = 16,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] in_value,
    output logic       in_ready,
    output logic       conv_done,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] seg,
    output logic [1:0] dig
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0] LAST_ITER = 3'd4;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;

    logic [4:0]       r_shift;
    logic [7:0]       r_bcd;
    logic [2:0]       r_iter;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_conv_done;

    logic [3:0]       w_adj_ones;
    logic [3:0]       w_adj_tens;
    logic [7:0]       w_bcd_next;
    logic [4:0]       w_shift_next;

    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_dig;
    logic [6:0]       r_seg;
    logic             w_cnt_wrap;
    logic [1:0]       w_dig_next;
    logic [3:0]       w_tens_next;
    logic [3:0]       w_ones_next;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_next;

    // Seven-segment pattern for one BCD digit; codes above 9 stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // State register for the IDLE/CONV controller.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update from the same pre-edge values, regardless of block order.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic: accept a sum in IDLE, leave CONV after the 5th step.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                if (r_iter == LAST_ITER) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,shift}.
    always_comb begin
        w_adj_ones   = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_adj_tens   = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_bcd_next   = {w_adj_tens[2:0], w_adj_ones, r_shift[4]};
        w_shift_next = {r_shift[3:0], 1'b0};
    end

    // Conversion datapath and result registers; results only move at completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_bcd       <= '0;
            r_iter      <= '0;
            r_tens      <= '0;
            r_ones      <= '0;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= w_last;
            if (w_accept) begin
                r_shift <= in_value;
                r_bcd   <= '0;
                r_iter  <= '0;
            end else if (r_state == CONV) begin
                r_shift <= w_shift_next;
                r_bcd   <= w_bcd_next;
                r_iter  <= r_iter + 3'd1;
                if (w_last) begin
                    r_tens <= w_bcd_next[7:4];
                    r_ones <= w_bcd_next[3:0];
                end
            end
        end
    end

    // Next scan position and the digit it will show, so seg lines up with dig.
    always_comb begin
        w_cnt_wrap  = (r_scan_cnt == CNT_LAST);
        w_dig_next  = w_cnt_wrap ? {r_dig[0], r_dig[1]} : r_dig;
        w_tens_next = w_last ? w_bcd_next[7:4] : r_tens;
        w_ones_next = w_last ? w_bcd_next[3:0] : r_ones;
        w_digit     = w_dig_next[1] ? w_tens_next : w_ones_next;
        w_seg_next  = seg_decode(w_digit);
        if (w_dig_next[1] && BLANK_LEADING && (w_tens_next == 4'd0)) begin
            w_seg_next = 7'h00;
        end
    end

    // Free-running scan counter with registered digit enable and segments.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_dig      <= 2'b01;
            r_seg      <= 7'h3F;
        end else begin
            r_scan_cnt <= w_cnt_wrap ? '0 : r_scan_cnt + CNT_W'(1);
            r_dig      <= w_dig_next;
            r_seg      <= w_seg_next;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign conv_done = r_conv_done;
    assign bcd_tens  = r_tens;
    assign bcd_ones  = r_ones;
    assign seg       = r_seg;
    assign dig       = r_dig;

endmodule
